// File: rtl/cpu_cond_pkg.sv
// cpu_cond_pkg -- shared constants for the condition flip-flop generator.
//   cond_e  : 3-bit condition codes carried on c_field.
//   state_e : result-holding FSM encoding (IDLE = no pending result,
//             HOLD = con_out holds an unacknowledged result).
package cpu_cond_pkg;

    typedef enum logic [2:0] {
        COND_Z   = 3'b000,  // bus == 0
        COND_NZ  = 3'b001,  // bus != 0
        COND_PL  = 3'b010,  // not negative, zero counts as positive
        COND_MI  = 3'b011,  // negative
        COND_GT  = 3'b100,  // strictly positive
        COND_LE  = 3'b101,  // negative or zero
        COND_T   = 3'b110,  // always true
        COND_F   = 3'b111   // always false
    } cond_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/con_ff_gen_if.sv
// con_ff_gen_if -- strobe/result bundle of the condition flip-flop generator.
//   con_in    : evaluate strobe
//   c_field   : condition code (cpu_cond_pkg::cond_e)
//   bus       : two's complement operand, DATA_W bits
//   ack       : consumer has taken the result
//   con_out   : registered condition result
//   con_valid : con_out holds an unacknowledged result
//   hist      : outcome history, bit 0 newest, HIST_D bits
//   taken_cnt : count of true outcomes, CNT_W bits, wraps
//   overrun   : sticky, a strobe was dropped
// master drives strobes and ack; slave is the generator.
interface con_ff_gen_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned HIST_D = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              con_in;
    logic [2:0]        c_field;
    logic [DATA_W-1:0] bus;
    logic              ack;
    logic              con_out;
    logic              con_valid;
    logic [HIST_D-1:0] hist;
    logic [CNT_W-1:0]  taken_cnt;
    logic              overrun;

    modport master (
        output con_in, c_field, bus, ack,
        input  con_out, con_valid, hist, taken_cnt, overrun
    );

    modport slave (
        input  con_in, c_field, bus, ack,
        output con_out, con_valid, hist, taken_cnt, overrun
    );
endinterface

// File: rtl/con_ff_gen_cond_eval.sv
// cond_eval -- purely combinational condition decoder.
//   c_field : condition code (cpu_cond_pkg::cond_e)
//   bus     : two's complement operand, DATA_W bits
//   flag    : condition result for c_field applied to bus
module cond_eval
    import cpu_cond_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        c_field,
    input  logic [DATA_W-1:0] bus,
    output logic              flag
);

    logic z;
    logic n;

    always_comb begin
        z    = (bus == '0);
        n    = bus[DATA_W-1];
        flag = 1'b0;
        case (cond_e'(c_field))
            COND_Z:  flag = z;
            COND_NZ: flag = !z;
            COND_PL: flag = !n;
            COND_MI: flag = n;
            COND_GT: flag = !n && !z;
            COND_LE: flag = n || z;
            COND_T:  flag = 1'b1;
            COND_F:  flag = 1'b0;
            default: flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/con_ff_gen.sv
// con_ff_gen -- condition flip-flop generator with result handshake,
// outcome history, taken counter and sticky overrun flag.
//   clock : rising-edge clock
//   clear : synchronous active-high reset, overrides strobe and ack
//   ff_if : con_ff_gen_if slave (strobe/operand in, registered results out)
// A strobe is accepted in IDLE, or in HOLD when ack frees the current
// result on the same edge; a strobe in HOLD without ack is dropped.
module con_ff_gen
    import cpu_cond_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned HIST_D = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic        clock,
    input  logic        clear,
    con_ff_gen_if.slave ff_if
);

    state_e            state;
    state_e            state_nxt;
    logic              accept;
    logic              drop;
    logic              flag;

    logic              con_out_r;
    logic              con_valid_r;
    logic [HIST_D-1:0] hist_r;
    logic [CNT_W-1:0]  taken_cnt_r;
    logic              overrun_r;

    cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .c_field (ff_if.c_field),
        .bus     (ff_if.bus),
        .flag    (flag)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                // ack is meaningless without a pending result
                if (ff_if.con_in) begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ff_if.ack) begin
                    accept    = ff_if.con_in;
                    state_nxt = ff_if.con_in ? HOLD : IDLE;
                end else if (ff_if.con_in) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            con_out_r   <= 1'b0;
            con_valid_r <= 1'b0;
            hist_r      <= '0;
            taken_cnt_r <= '0;
            overrun_r   <= 1'b0;
        end else begin
            state       <= state_nxt;
            // con_valid is kept as its own flop so every output is a register
            con_valid_r <= (state_nxt == HOLD);
            if (accept) begin
                con_out_r <= flag;
                hist_r    <= (hist_r << 1) | HIST_D'(flag);
                if (flag) begin
                    taken_cnt_r <= taken_cnt_r + CNT_W'(1);
                end
            end
            if (drop) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign ff_if.con_out   = con_out_r;
    assign ff_if.con_valid = con_valid_r;
    assign ff_if.hist      = hist_r;
    assign ff_if.taken_cnt = taken_cnt_r;
    assign ff_if.overrun   = overrun_r;

endmodule

// File: tb/tb_con_ff_gen.sv
// tb_con_ff_gen -- directed self-checking bench for con_ff_gen.
// Three instances: default widths, CNT_W=4 (counter wrap), DATA_W=8.
module tb_con_ff_gen;

    logic clock;
    logic clear;

    int unsigned n_checks;
    int unsigned n_pass;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    con_ff_gen_if #(.DATA_W(32), .HIST_D(8), .CNT_W(16)) if_a ();
    con_ff_gen_if #(.DATA_W(32), .HIST_D(8), .CNT_W(4))  if_w ();
    con_ff_gen_if #(.DATA_W(8),  .HIST_D(8), .CNT_W(16)) if_n ();

    con_ff_gen #(.DATA_W(32), .HIST_D(8), .CNT_W(16)) dut_a (
        .clock (clock),
        .clear (clear),
        .ff_if (if_a.slave)
    );

    con_ff_gen #(.DATA_W(32), .HIST_D(8), .CNT_W(4)) dut_w (
        .clock (clock),
        .clear (clear),
        .ff_if (if_w.slave)
    );

    con_ff_gen #(.DATA_W(8), .HIST_D(8), .CNT_W(16)) dut_n (
        .clock (clock),
        .clear (clear),
        .ff_if (if_n.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_a_all_zero(input string tag);
        check({tag, " con_out"},   32'(if_a.con_out),   32'h0);
        check({tag, " con_valid"}, 32'(if_a.con_valid), 32'h0);
        check({tag, " hist"},      32'(if_a.hist),      32'h0);
        check({tag, " taken_cnt"}, 32'(if_a.taken_cnt), 32'h0);
        check({tag, " overrun"},   32'(if_a.overrun),   32'h0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        if_a.con_in = 1'b0;
        if_a.ack    = 1'b0;
        step();
        clear = 1'b0;
    endtask

    // expected flag per code, bit k = code k
    logic [31:0] sweep_bus [4];
    logic [7:0]  sweep_exp [4];
    logic [3:0]  b2b_code  [4];

    initial begin
        n_checks = 0;
        n_pass   = 0;

        sweep_bus = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
        sweep_exp = '{8'h65, 8'h56, 8'h6A, 8'h56};
        b2b_code  = '{4'd6, 4'd7, 4'd6, 4'd6};

        clear = 1'b1;
        if_a.con_in = 1'b0; if_a.c_field = 3'b000; if_a.bus = '0; if_a.ack = 1'b0;
        if_w.con_in = 1'b0; if_w.c_field = 3'b000; if_w.bus = '0; if_w.ack = 1'b0;
        if_n.con_in = 1'b0; if_n.c_field = 3'b000; if_n.bus = '0; if_n.ack = 1'b0;
        step();
        step();
        clear = 1'b0;

        // reset state
        check_a_all_zero("reset");

        // decode sweep, one strobe per cycle with ack held high
        if_a.con_in = 1'b1;
        if_a.ack    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 8; c++) begin
                if_a.bus     = sweep_bus[i];
                if_a.c_field = 3'(c);
                step();
                check($sformatf("decode bus=%0h code=%0d", sweep_bus[i], c),
                      32'(if_a.con_out), 32'(sweep_exp[i][c]));
            end
        end
        do_clear();

        // handshake: result held, second strobe dropped
        if_a.bus     = '0;
        if_a.c_field = 3'b110;
        if_a.con_in  = 1'b1;
        if_a.ack     = 1'b0;
        step();
        if_a.con_in  = 1'b0;
        step(); step(); step();
        if_a.c_field = 3'b111;
        if_a.con_in  = 1'b1;
        step();
        if_a.con_in  = 1'b0;
        check("hs con_out",   32'(if_a.con_out),   32'h1);
        check("hs overrun",   32'(if_a.overrun),   32'h1);
        check("hs taken_cnt", 32'(if_a.taken_cnt), 32'h1);
        check("hs hist",      32'(if_a.hist),      32'h01);
        check("hs con_valid", 32'(if_a.con_valid), 32'h1);
        // ack without strobe releases the result, value is kept
        if_a.ack = 1'b1;
        step();
        check("ack release con_valid", 32'(if_a.con_valid), 32'h0);
        check("ack release con_out",   32'(if_a.con_out),   32'h1);
        // ack in IDLE does nothing; overrun stays sticky
        step();
        check("idle ack con_valid", 32'(if_a.con_valid), 32'h0);
        check("sticky overrun",     32'(if_a.overrun),   32'h1);
        // strobe in IDLE is accepted even with ack low
        if_a.ack     = 1'b0;
        if_a.c_field = 3'b111;
        if_a.con_in  = 1'b1;
        step();
        if_a.con_in  = 1'b0;
        check("idle strobe con_out",   32'(if_a.con_out),   32'h0);
        check("idle strobe hist",      32'(if_a.hist),      32'h02);
        check("idle strobe taken_cnt", 32'(if_a.taken_cnt), 32'h1);
        do_clear();
        check("post clear overrun", 32'(if_a.overrun), 32'h0);

        // back-to-back accepted strobes, flags 1,0,1,1
        if_a.con_in = 1'b1;
        if_a.ack    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if_a.c_field = b2b_code[k][2:0];
            step();
            check($sformatf("b2b con_valid %0d", k), 32'(if_a.con_valid), 32'h1);
        end
        check("b2b hist",      32'(if_a.hist),      32'h0B);
        check("b2b taken_cnt", 32'(if_a.taken_cnt), 32'h3);
        check("b2b overrun",   32'(if_a.overrun),   32'h0);

        // clear in HOLD with a strobe on the same edge
        if_a.c_field = 3'b110;
        if_a.con_in  = 1'b1;
        if_a.ack     = 1'b0;
        clear        = 1'b1;
        step();
        clear        = 1'b0;
        if_a.con_in  = 1'b0;
        check_a_all_zero("mid clear");
        step();
        check("mid clear no count", 32'(if_a.taken_cnt), 32'h0);
        check("mid clear idle",     32'(if_a.con_valid), 32'h0);

        // counter wrap with CNT_W=4
        if_w.c_field = 3'b110;
        if_w.ack     = 1'b1;
        if_w.con_in  = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 15) check("wrap cnt 15", 32'(if_w.taken_cnt), 32'hF);
            if (k == 16) check("wrap cnt 16", 32'(if_w.taken_cnt), 32'h0);
        end
        if_w.con_in = 1'b0;
        check("wrap taken_cnt", 32'(if_w.taken_cnt), 32'h1);
        check("wrap hist",      32'(if_w.hist),      32'hFF);

        // narrow operand, DATA_W=8
        if_n.ack     = 1'b1;
        if_n.con_in  = 1'b1;
        if_n.bus     = 8'h80;
        if_n.c_field = 3'b011;
        step();
        check("w8 0x80 MI", 32'(if_n.con_out), 32'h1);
        if_n.c_field = 3'b010;
        step();
        check("w8 0x80 PL", 32'(if_n.con_out), 32'h0);
        if_n.bus     = 8'h7F;
        if_n.c_field = 3'b100;
        step();
        check("w8 0x7F GT", 32'(if_n.con_out), 32'h1);
        if_n.con_in  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/con_ff_gen.md
CON_FF_GEN -- requirements
Module: con_ff_gen

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of the bus operand under test.
REQ-003 The block SHALL have parameter HIST_D, default 8, meaning the number of entries in the outcome history.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of the taken counter.
REQ-005 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port con_in, input, 1 bit: evaluate strobe.
REQ-008 The block SHALL have port c_field, input, 3 bits: condition code.
REQ-009 The block SHALL have port bus, input, DATA_W bits: operand, two's complement.
REQ-010 The block SHALL have port ack, input, 1 bit: consumer has taken the result.
REQ-011 The block SHALL have port con_out, output, 1 bit: registered condition result.
REQ-012 The block SHALL have port con_valid, output, 1 bit: con_out holds an unacknowledged result.
REQ-013 The block SHALL have port hist, output, HIST_D bits: outcome history, bit 0 newest.
REQ-014 The block SHALL have port taken_cnt, output, CNT_W bits: count of true outcomes.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky; set when a strobe was dropped.

Function
REQ-016 Conditions SHALL decode as follows, with Z = (bus == 0) and N = bus[DATA_W-1]:
- 000 Z
- 001 !Z
- 010 !N (zero counts as positive)
- 011 N
- 100 !N & !Z
- 101 N | Z
- 110 true
- 111 false
REQ-017 The state machine SHALL have two states: IDLE (con_valid=0) and HOLD (con_valid=1).
REQ-018 A strobe is accepted at a rising edge where con_in=1 and (state==IDLE or ack=1).
REQ-019 On an accepted strobe, con_out SHALL take the flag evaluated from the same-edge c_field and bus, and the state SHALL go to HOLD; latency is 1 cycle.
REQ-020 In HOLD with ack=1 and con_in=0, the state SHALL go to IDLE and con_out SHALL hold its value.
REQ-021 In HOLD with ack=1 and con_in=1, the new strobe SHALL be accepted and the state SHALL stay in HOLD (back-to-back throughput of 1 per cycle).
REQ-022 In HOLD with ack=0 and con_in=1, the strobe SHALL be dropped: con_out, hist and taken_cnt are unchanged, and overrun is set to 1.
REQ-023 ack in IDLE SHALL be ignored.
REQ-024 con_out SHALL change only on an accepted strobe or on clear.
REQ-025 On each accepted strobe, hist SHALL shift left by one with the new flag into bit 0; the oldest bit is discarded.
REQ-026 On each accepted strobe whose flag is 1, taken_cnt SHALL increment by 1, wrapping from 2^CNT_W-1 to 0 without a flag.
REQ-027 overrun SHALL remain 1 until clear.
REQ-028 Evaluation SHALL be combinational from the inputs sampled at the edge, with no registered input stage.

Reset
REQ-029 When clear=1 at a rising edge, the block SHALL set state=IDLE, con_out=0, con_valid=0, hist=0, taken_cnt=0 and overrun=0.
REQ-030 clear SHALL take priority over con_in and ack on the same edge, and a result pending in HOLD SHALL be discarded.
REQ-031 All outputs SHALL be register-driven, so no output glitches during clear.

Structure
REQ-032 The codes 000..111 and the IDLE/HOLD state encoding SHALL be constants in the shared package cpu_cond_pkg.
REQ-033 The condition evaluator SHALL be the sub-module cond_eval (inputs c_field and bus, output flag), parametrised by DATA_W.
REQ-034 The state, history and counter registers SHALL live in con_ff_gen.

Verification
REQ-035 Decode sweep: DATA_W=32; bus in {0, 1, 0x80000000, 0x7FFFFFFF}; every c_field with ack=1 -> con_out matches REQ-016 one cycle later (e.g. bus=0, 100 -> 0; bus=0, 101 -> 1).
REQ-036 Handshake: strobe with code 110; hold ack=0 for 3 cycles; strobe again with code 111 -> con_out stays 1, overrun=1, taken_cnt=1, hist=0x01.
REQ-037 Back-to-back: 4 consecutive strobes with ack=1 and flags 1,0,1,1 -> hist=0x0B, taken_cnt=3, con_valid=1 throughout, overrun=0.
REQ-038 Wrap: CNT_W=4; 17 strobes with code 110 -> taken_cnt=1 and hist=0xFF.
REQ-039 Reset mid-operation: in HOLD with con_in=1 and clear=1 on the same edge -> all outputs 0 next cycle, and the strobe is not counted.
REQ-040 Width: DATA_W=8, bus=0x80, code 011 -> con_out=1; bus=0x7F, code 100 -> con_out=1.
